// File: rtl/vdp_pkg.sv
// Shared VDP definitions: video mode codes, control-port command codes,
// register indices and status/register bit positions.
package vdp_pkg;

  localparam int unsigned VDP_ADDR_W = 14;

  typedef enum logic [2:0] {
    MODE_TEXT  = 3'd0,
    MODE_GFX1  = 3'd1,
    MODE_GFX2  = 3'd2,
    MODE_MULTI = 3'd3,
    MODE_4     = 3'd4
  } vdp_mode_t;

  // Upper two bits of the second control byte
  typedef enum logic [1:0] {
    CODE_VRD  = 2'b00,
    CODE_VWR  = 2'b01,
    CODE_REG  = 2'b10,
    CODE_VWR2 = 2'b11
  } vdp_code_t;

  typedef enum logic {
    LATCH_FIRST,
    LATCH_SECOND
  } vdp_latch_t;

  typedef enum logic {
    XFER_IDLE,
    XFER_RD_WAIT
  } vdp_xfer_t;

  localparam int unsigned REG_MODE0   = 0;
  localparam int unsigned REG_MODE1   = 1;
  localparam int unsigned REG_NAME    = 2;
  localparam int unsigned REG_COLOR   = 3;
  localparam int unsigned REG_FONT    = 4;
  localparam int unsigned REG_SATTR   = 5;
  localparam int unsigned REG_SPAT    = 6;
  localparam int unsigned REG_COLOURS = 7;
  localparam int unsigned REG_XSCROLL = 8;
  localparam int unsigned REG_YSCROLL = 9;
  localparam int unsigned REG_LINE    = 10;

  localparam int unsigned R0_M2       = 1;
  localparam int unsigned R0_M4       = 2;
  localparam int unsigned R0_LINE_IE  = 4;
  localparam int unsigned R1_MAG      = 0;
  localparam int unsigned R1_SIZE     = 1;
  localparam int unsigned R1_MULTI    = 3;
  localparam int unsigned R1_TEXT     = 4;
  localparam int unsigned R1_FRAME_IE = 5;
  localparam int unsigned R1_VIDEO_ON = 6;

  localparam int unsigned ST_FRAME = 7;
  localparam int unsigned ST_OVER  = 6;
  localparam int unsigned ST_COLL  = 5;

endpackage

// File: rtl/vdp_reg_decode.sv
// Combinational decode of VDP registers R0-R7 into the video mode,
// sprite options, table base addresses and colours.
module vdp_reg_decode
  import vdp_pkg::*;
#(
  parameter int unsigned ADDR_W = 14
) (
  input  logic [7:0]        r0,
  input  logic [7:0]        r1,
  input  logic [7:0]        r2,
  input  logic [7:0]        r3,
  input  logic [7:0]        r4,
  input  logic [7:0]        r5,
  input  logic [7:0]        r6,
  input  logic [7:0]        r7,
  output vdp_mode_t         mode,
  output logic              video_on,
  output logic              spr_large,
  output logic              spr_mag,
  output logic [ADDR_W-1:0] name_tbl,
  output logic [ADDR_W-1:0] color_tbl,
  output logic [ADDR_W-1:0] font_tbl,
  output logic [ADDR_W-1:0] spr_attr,
  output logic [ADDR_W-1:0] spr_pat,
  output logic [3:0]        text_color,
  output logic [3:0]        back_color
);

  logic unused_bits;
  assign unused_bits = &{1'b0, r0[7:3], r0[0], r1[7], r1[5], r1[2],
                         r2[7:4], r4[7:3], r5[7], r6[7:3]};

  always_comb begin
    // Mode 4 overrides everything; text beats multicolour beats gfx II
    mode = MODE_GFX1;
    if (r0[R0_M4])         mode = MODE_4;
    else if (r1[R1_TEXT])  mode = MODE_TEXT;
    else if (r1[R1_MULTI]) mode = MODE_MULTI;
    else if (r0[R0_M2])    mode = MODE_GFX2;

    name_tbl  = (mode == MODE_4)    ? ADDR_W'({r2[3:1], 11'b0}) : ADDR_W'({r2[3:0], 10'b0});
    color_tbl = (mode == MODE_GFX2) ? ADDR_W'({r3[7], 13'b0})   : ADDR_W'({r3, 6'b0});
    if (mode == MODE_4)         font_tbl = '0;
    else if (mode == MODE_GFX2) font_tbl = ADDR_W'({r4[2], 13'b0});
    else                        font_tbl = ADDR_W'({r4[2:0], 11'b0});
    spr_attr = ADDR_W'({r5[6:0], 7'b0});
    spr_pat  = ADDR_W'({r6[2:0], 11'b0});
  end

  assign video_on   = r1[R1_VIDEO_ON];
  assign spr_large  = r1[R1_SIZE];
  assign spr_mag    = r1[R1_MAG];
  assign text_color = r7[7:4];
  assign back_color = r7[3:0];

endmodule

// File: rtl/vdp_port_ctrl.sv
// VDP CPU-port controller: control latch, VRAM access sequencing, registers, status and IRQ.
// Build option VDP_LINE_IRQ_EN adds the R10-driven line interrupt counter.
module vdp_port_ctrl
  import vdp_pkg::*;
#(
  parameter int unsigned NUM_REGS = 11,
  parameter int unsigned ADDR_W   = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_sel_ctrl,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              busy,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_wr,
  output logic              vram_rd,
  output logic [7:0]        vram_wdata,
  input  logic [7:0]        vram_rdata,
  input  logic              vblank_pulse,
  input  logic              line_pulse,
  input  logic              active_line,
  input  logic              spr_coll,
  input  logic              spr_over,
  input  logic [4:0]        spr5_num,
  output logic [2:0]        mode,
  output logic              video_on,
  output logic              spr_large,
  output logic              spr_mag,
  output logic [ADDR_W-1:0] name_tbl,
  output logic [ADDR_W-1:0] color_tbl,
  output logic [ADDR_W-1:0] font_tbl,
  output logic [ADDR_W-1:0] spr_attr,
  output logic [ADDR_W-1:0] spr_pat,
  output logic [3:0]        text_color,
  output logic [3:0]        back_color,
  output logic [7:0]        x_scroll,
  output logic [7:0]        y_scroll,
  output logic              irq_n
);

  logic [7:0]        regs [NUM_REGS];
  vdp_latch_t        latch;
  vdp_xfer_t         xfer;
  logic [7:0]        lo_byte;
  logic [7:0]        rbuf;
  logic [ADDR_W-1:0] addr;
  logic              vram_rd_q;
  logic              vram_wr_q;
  logic              frame_f, over_f, coll_f, line_f;
  logic [7:0]        status;
  vdp_mode_t         dec_mode;

  logic accept, ctrl_wr, ctrl_rd, data_wr, data_rd;
  logic [ADDR_W-1:0] ctrl_addr;

  // Strobes arriving while a prefetch is outstanding are dropped
  assign accept    = (xfer == XFER_IDLE);
  assign ctrl_wr   = accept & cpu_wr & cpu_sel_ctrl;
  assign ctrl_rd   = accept & cpu_rd & cpu_sel_ctrl;
  assign data_wr   = accept & cpu_wr & ~cpu_sel_ctrl;
  assign data_rd   = accept & cpu_rd & ~cpu_sel_ctrl;
  assign ctrl_addr = ADDR_W'({cpu_din[5:0], lo_byte});

  always_comb begin
    status           = '0;
    status[ST_FRAME] = frame_f;
    status[ST_OVER]  = over_f;
    status[ST_COLL]  = coll_f;
    status[4:0]      = spr5_num;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      latch      <= LATCH_FIRST;
      xfer       <= XFER_IDLE;
      lo_byte    <= '0;
      rbuf       <= '0;
      addr       <= '0;
      vram_addr  <= '0;
      vram_wdata <= '0;
      vram_rd_q  <= 1'b0;
      vram_wr_q  <= 1'b0;
      cpu_dout   <= '0;
      frame_f    <= 1'b0;
      over_f     <= 1'b0;
      coll_f     <= 1'b0;
    end else begin
      vram_rd_q <= 1'b0;
      vram_wr_q <= 1'b0;
      // A new event in the same cycle as a status read keeps the flag set
      frame_f <= vblank_pulse | (frame_f & ~ctrl_rd);
      over_f  <= spr_over     | (over_f  & ~ctrl_rd);
      coll_f  <= spr_coll     | (coll_f  & ~ctrl_rd);

      case (xfer)
        XFER_IDLE: begin
          if (ctrl_wr) begin
            if (latch == LATCH_FIRST) begin
              lo_byte <= cpu_din;
              latch   <= LATCH_SECOND;
            end else begin
              latch <= LATCH_FIRST;
              addr  <= ctrl_addr;
              case (cpu_din[7:6])
                CODE_VRD: begin
                  vram_rd_q <= 1'b1;
                  vram_addr <= ctrl_addr;
                  xfer      <= XFER_RD_WAIT;
                end
                CODE_REG: begin
                  for (int unsigned i = 0; i < NUM_REGS; i++)
                    if (32'(cpu_din[3:0]) == i) regs[i] <= lo_byte;
                end
                default: ;
              endcase
            end
          end else if (ctrl_rd) begin
            latch    <= LATCH_FIRST;
            cpu_dout <= status;
          end else if (data_wr) begin
            latch      <= LATCH_FIRST;
            vram_wr_q  <= 1'b1;
            vram_addr  <= addr;
            vram_wdata <= cpu_din;
            rbuf       <= cpu_din;
            addr       <= addr + ADDR_W'(1);
          end else if (data_rd) begin
            latch     <= LATCH_FIRST;
            cpu_dout  <= rbuf;
            vram_rd_q <= 1'b1;
            vram_addr <= addr;
            xfer      <= XFER_RD_WAIT;
          end
        end
        XFER_RD_WAIT: begin
          // First wait cycle carries the strobe; data is captured on the second
          if (!vram_rd_q) begin
            rbuf <= vram_rdata;
            addr <= addr + ADDR_W'(1);
            xfer <= XFER_IDLE;
          end
        end
      endcase
    end
  end

`ifdef VDP_LINE_IRQ_EN
  logic [7:0] line_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      line_cnt <= '0;
      line_f   <= 1'b0;
    end else begin
      line_f <= line_f & ~ctrl_rd;
      if (!active_line) begin
        line_cnt <= regs[REG_LINE];
      end else if (line_pulse) begin
        if (line_cnt == 8'd0) begin
          line_cnt <= regs[REG_LINE];
          line_f   <= 1'b1;
        end else begin
          line_cnt <= line_cnt - 8'd1;
        end
      end
    end
  end
`else
  logic unused_line;
  assign unused_line = &{1'b0, line_pulse, active_line, regs[REG_LINE]};
  assign line_f      = 1'b0;
`endif

  // Gate the registered strobes so a reset cycle never reaches VRAM
  assign vram_rd = vram_rd_q & ~reset;
  assign vram_wr = vram_wr_q & ~reset;
  assign busy    = (xfer == XFER_RD_WAIT);
  assign irq_n   = ~((frame_f & regs[REG_MODE1][R1_FRAME_IE]) |
                     (line_f  & regs[REG_MODE0][R0_LINE_IE]));

  assign x_scroll = regs[REG_XSCROLL];
  assign y_scroll = regs[REG_YSCROLL];
  assign mode     = dec_mode;

  vdp_reg_decode #(.ADDR_W(ADDR_W)) u_decode (
    .r0         (regs[REG_MODE0]),
    .r1         (regs[REG_MODE1]),
    .r2         (regs[REG_NAME]),
    .r3         (regs[REG_COLOR]),
    .r4         (regs[REG_FONT]),
    .r5         (regs[REG_SATTR]),
    .r6         (regs[REG_SPAT]),
    .r7         (regs[REG_COLOURS]),
    .mode       (dec_mode),
    .video_on   (video_on),
    .spr_large  (spr_large),
    .spr_mag    (spr_mag),
    .name_tbl   (name_tbl),
    .color_tbl  (color_tbl),
    .font_tbl   (font_tbl),
    .spr_attr   (spr_attr),
    .spr_pat    (spr_pat),
    .text_color (text_color),
    .back_color (back_color)
  );

endmodule

// File: tb/tb_vdp_port_ctrl.sv
// Self-checking bench for vdp_port_ctrl: register decode table plus directed
// VRAM, status/IRQ, line-IRQ and reset sequences against a simple VRAM model.
module tb_vdp_port_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_sel_ctrl = 1'b0, cpu_wr = 1'b0, cpu_rd = 1'b0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  cpu_dout;
  logic        busy;
  logic [13:0] vram_addr;
  logic        vram_wr, vram_rd;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata = '0;
  logic        vblank_pulse = 1'b0, line_pulse = 1'b0, active_line = 1'b0;
  logic        spr_coll = 1'b0, spr_over = 1'b0;
  logic [4:0]  spr5_num = 5'h0A;
  logic [2:0]  mode;
  logic        video_on, spr_large, spr_mag;
  logic [13:0] name_tbl, color_tbl, font_tbl, spr_attr, spr_pat;
  logic [3:0]  text_color, back_color;
  logic [7:0]  x_scroll, y_scroll;
  logic        irq_n;

  vdp_port_ctrl #(.NUM_REGS(11), .ADDR_W(14)) dut (
    .clk(clk), .reset(reset), .cpu_sel_ctrl(cpu_sel_ctrl), .cpu_wr(cpu_wr),
    .cpu_rd(cpu_rd), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .busy(busy),
    .vram_addr(vram_addr), .vram_wr(vram_wr), .vram_rd(vram_rd),
    .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
    .vblank_pulse(vblank_pulse), .line_pulse(line_pulse), .active_line(active_line),
    .spr_coll(spr_coll), .spr_over(spr_over), .spr5_num(spr5_num), .mode(mode),
    .video_on(video_on), .spr_large(spr_large), .spr_mag(spr_mag),
    .name_tbl(name_tbl), .color_tbl(color_tbl), .font_tbl(font_tbl),
    .spr_attr(spr_attr), .spr_pat(spr_pat), .text_color(text_color),
    .back_color(back_color), .x_scroll(x_scroll), .y_scroll(y_scroll), .irq_n(irq_n)
  );

  always #5 clk = ~clk;

`ifdef VDP_LINE_IRQ_EN
  localparam bit LINE_IRQ = 1'b1;
`else
  localparam bit LINE_IRQ = 1'b0;
`endif

  // VRAM model: synchronous write, read data valid the cycle after vram_rd
  logic [7:0] mem [16384];
  int unsigned rd_count = 0;
  always @(posedge clk) begin
    if (vram_wr) mem[vram_addr] <= vram_wdata;
    if (vram_rd) begin
      vram_rdata <= mem[vram_addr];
      rd_count   <= rd_count + 1;
    end
  end

  int   errors = 0;
  int   checks = 0;
  logic busy_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // One strobe, then idle so the next strobe is three cycles later
  task automatic access(input logic sel, input logic wr, input logic [7:0] din);
    cpu_sel_ctrl = sel; cpu_wr = wr; cpu_rd = ~wr; cpu_din = din;
    cyc();
    cpu_wr = 1'b0; cpu_rd = 1'b0;
    @(negedge clk); busy_seen = busy;
    cyc(); cyc();
  endtask

  task automatic ctrl_pair(input logic [7:0] b0, input logic [7:0] b1);
    access(1'b1, 1'b1, b0);
    access(1'b1, 1'b1, b1);
  endtask

  task automatic data_write(input logic [7:0] d); access(1'b0, 1'b1, d); endtask
  task automatic data_read();   access(1'b0, 1'b0, 8'h00); endtask
  task automatic status_read(); access(1'b1, 1'b0, 8'h00); endtask

  task automatic pulse_vblank();
    vblank_pulse = 1'b1; cyc(); vblank_pulse = 1'b0; cyc();
  endtask

  task automatic pulse_line();
    line_pulse = 1'b1; cyc(); line_pulse = 1'b0; cyc();
  endtask

  typedef struct {
    logic [3:0]  idx;
    logic [7:0]  val;
    logic [2:0]  mode;
    logic [13:0] name, color, font, sattr, spat;
    logic [7:0]  tcbc;
  } vec_t;
  vec_t vecs [14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n0;
    vecs[0]  = '{4'h2, 8'h0F, 3'd1, 14'h3C00, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 8'h00};
    vecs[1]  = '{4'h3, 8'hFF, 3'd1, 14'h3C00, 14'h3FC0, 14'h0000, 14'h0000, 14'h0000, 8'h00};
    vecs[2]  = '{4'h4, 8'h07, 3'd1, 14'h3C00, 14'h3FC0, 14'h3800, 14'h0000, 14'h0000, 8'h00};
    vecs[3]  = '{4'h0, 8'h02, 3'd2, 14'h3C00, 14'h2000, 14'h2000, 14'h0000, 14'h0000, 8'h00};
    vecs[4]  = '{4'h0, 8'h06, 3'd4, 14'h3800, 14'h3FC0, 14'h0000, 14'h0000, 14'h0000, 8'h00};
    vecs[5]  = '{4'h0, 8'h00, 3'd1, 14'h3C00, 14'h3FC0, 14'h3800, 14'h0000, 14'h0000, 8'h00};
    vecs[6]  = '{4'h1, 8'h10, 3'd0, 14'h3C00, 14'h3FC0, 14'h3800, 14'h0000, 14'h0000, 8'h00};
    vecs[7]  = '{4'h1, 8'h08, 3'd3, 14'h3C00, 14'h3FC0, 14'h3800, 14'h0000, 14'h0000, 8'h00};
    vecs[8]  = '{4'h1, 8'h18, 3'd0, 14'h3C00, 14'h3FC0, 14'h3800, 14'h0000, 14'h0000, 8'h00};
    vecs[9]  = '{4'h5, 8'h7F, 3'd0, 14'h3C00, 14'h3FC0, 14'h3800, 14'h3F80, 14'h0000, 8'h00};
    vecs[10] = '{4'h6, 8'h05, 3'd0, 14'h3C00, 14'h3FC0, 14'h3800, 14'h3F80, 14'h2800, 8'h00};
    vecs[11] = '{4'h2, 8'h05, 3'd0, 14'h1400, 14'h3FC0, 14'h3800, 14'h3F80, 14'h2800, 8'h00};
    vecs[12] = '{4'h7, 8'hA5, 3'd0, 14'h1400, 14'h3FC0, 14'h3800, 14'h3F80, 14'h2800, 8'hA5};
    vecs[13] = '{4'hB, 8'h3C, 3'd0, 14'h1400, 14'h3FC0, 14'h3800, 14'h3F80, 14'h2800, 8'hA5};

    repeat (3) cyc();
    reset = 1'b0;
    cyc();

    check("rst_irq_n", irq_n, 1);
    check("rst_busy", busy, 0);
    check("rst_cpu_dout", cpu_dout, 8'h00);
    check("rst_mode", mode, 3'd1);
    check("rst_name_tbl", name_tbl, 0);
    check("rst_vram_rd", vram_rd, 0);
    check("rst_vram_wr", vram_wr, 0);
    check("rst_x_scroll", x_scroll, 0);

    ctrl_pair(8'h05, 8'h81);
    check("r1_spr_large", spr_large, 0);
    check("r1_spr_mag", spr_mag, 1);
    check("r1_video_on", video_on, 0);
    ctrl_pair(8'hE0, 8'h81);
    check("r1b_video_on", video_on, 1);
    check("r1b_spr_mag", spr_mag, 0);

    for (int i = 0; i < 14; i++) begin
      ctrl_pair(vecs[i].val, {4'h8, vecs[i].idx});
      check($sformatf("vec%0d_mode", i), mode, vecs[i].mode);
      check($sformatf("vec%0d_name", i), name_tbl, vecs[i].name);
      check($sformatf("vec%0d_color", i), color_tbl, vecs[i].color);
      check($sformatf("vec%0d_font", i), font_tbl, vecs[i].font);
      check($sformatf("vec%0d_sattr", i), spr_attr, vecs[i].sattr);
      check($sformatf("vec%0d_spat", i), spr_pat, vecs[i].spat);
      check($sformatf("vec%0d_colours", i), {text_color, back_color}, vecs[i].tcbc);
    end

    ctrl_pair(8'h12, 8'h88);
    ctrl_pair(8'h34, 8'h89);
    check("x_scroll", x_scroll, 8'h12);
    check("y_scroll", y_scroll, 8'h34);

    // VRAM writes with auto-increment
    ctrl_pair(8'h00, 8'h7F);
    data_write(8'hAA);
    check("wr_no_busy", busy_seen, 0);
    data_write(8'hBB);
    data_write(8'hCC);
    check("wr_3f00", mem[14'h3F00], 8'hAA);
    check("wr_3f01", mem[14'h3F01], 8'hBB);
    check("wr_3f02", mem[14'h3F02], 8'hCC);

    // Read-ahead: setup prefetch, then each read returns the buffer
    ctrl_pair(8'h00, 8'h40);
    data_write(8'h12);
    data_write(8'h34);
    ctrl_pair(8'h00, 8'h00);
    check("pf_busy", busy_seen, 1);
    data_read();
    check("rd0_dout", cpu_dout, 8'h12);
    check("rd0_busy", busy_seen, 1);
    data_read();
    check("rd1_dout", cpu_dout, 8'h34);
    check("rd1_busy_done", busy, 0);

    // Address wrap 3FFF -> 0000
    ctrl_pair(8'hFF, 8'h7F);
    data_write(8'h55);
    data_write(8'h66);
    check("wrap_3fff", mem[14'h3FFF], 8'h55);
    check("wrap_0000", mem[14'h0000], 8'h66);
    data_read();
    check("rbuf_from_write", cpu_dout, 8'h66);
    data_read();
    check("rd_after_wrap", cpu_dout, 8'h34);

    // Frame interrupt and status
    ctrl_pair(8'h20, 8'h81);
    check("irq_idle", irq_n, 1);
    pulse_vblank();
    check("irq_frame", irq_n, 0);
    status_read();
    check("status_frame", cpu_dout, 8'h8A);
    check("irq_cleared", irq_n, 1);
    pulse_vblank();
    cpu_sel_ctrl = 1'b1; cpu_rd = 1'b1; vblank_pulse = 1'b1;
    cyc();
    cpu_rd = 1'b0; vblank_pulse = 1'b0;
    cyc(); cyc();
    check("status_set_wins_dout", cpu_dout, 8'h8A);
    check("status_set_wins_irq", irq_n, 0);
    status_read();
    check("status_frame2", cpu_dout, 8'h8A);
    status_read();
    check("status_clear", cpu_dout, 8'h0A);
    spr_coll = 1'b1; cyc(); spr_coll = 1'b0; cyc();
    status_read();
    check("status_coll", cpu_dout, 8'h2A);
    spr_over = 1'b1; cyc(); spr_over = 1'b0; cyc();
    status_read();
    check("status_over", cpu_dout, 8'h4A);
    check("irq_no_frame", irq_n, 1);

    // Status read returns the latch to the first byte
    access(1'b1, 1'b1, 8'h34);
    status_read();
    ctrl_pair(8'h07, 8'h87);
    check("latch_reset_colours", {text_color, back_color}, 8'h07);

    // Line interrupt: R10=2, third active-line pulse underflows
    ctrl_pair(8'h02, 8'h8A);
    ctrl_pair(8'h10, 8'h80);
    cyc();
    active_line = 1'b1;
    pulse_line();
    pulse_line();
    check("line_irq_early", irq_n, 1);
    pulse_line();
    check("line_irq", irq_n, LINE_IRQ ? 1'b0 : 1'b1);
    status_read();
    check("line_irq_cleared", irq_n, 1);
    active_line = 1'b0;
    cyc();

    // Reset during a prefetch: no strobe reaches VRAM, nothing captured
    n0 = rd_count;
    cpu_sel_ctrl = 1'b0; cpu_rd = 1'b1;
    cyc();
    cpu_rd = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_vram_rd", vram_rd, 0);
    cyc();
    reset = 1'b0;
    cyc(); cyc(); cyc();
    check("rst_mid_no_strobe", rd_count, n0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_dout", cpu_dout, 8'h00);
    data_read();
    check("rst_mid_rbuf", cpu_dout, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
